// File: rtl/ccip_mmio_csr_responder_if.sv
// rtl/ccip_mmio_csr_responder_if.sv - CCI-P MMIO request (Rx c0) and read response (Tx c2) bundle
// master drives c0 and receives c2; slave is the AFU-side responder.
interface ccip_mmio_csr_responder_if;
    logic        c0_mmio_rd_valid;
    logic        c0_mmio_wr_valid;
    logic [15:0] c0_address;
    logic [1:0]  c0_length;
    logic [8:0]  c0_tid;
    logic [63:0] c0_data;

    logic        c2_mmio_rd_valid;
    logic [8:0]  c2_tid;
    logic [63:0] c2_data;

    modport master (
        output c0_mmio_rd_valid, c0_mmio_wr_valid, c0_address, c0_length, c0_tid, c0_data,
        input  c2_mmio_rd_valid, c2_tid, c2_data
    );

    modport slave (
        input  c0_mmio_rd_valid, c0_mmio_wr_valid, c0_address, c0_length, c0_tid, c0_data,
        output c2_mmio_rd_valid, c2_tid, c2_data
    );
endinterface

// File: rtl/ccip_mmio_csr_responder.sv
// rtl/ccip_mmio_csr_responder.sv - AFU CSR file answering host MMIO reads with a fixed 2-cycle latency
// Optional CCIP_MMIO_CNT_EN adds a read-only {rd_cnt, wr_cnt} register after the user CSRs.
module ccip_mmio_csr_responder #(
    parameter logic [63:0] AFU_ID_L     = 64'h0,
    parameter logic [63:0] AFU_ID_H     = 64'h0,
    parameter int          NUM_USER_CSR = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    ccip_mmio_csr_responder_if.slave     mmio,
    input  logic [63:0]                  status_i,
    output logic [63:0]                  ctrl_o,
    output logic                         start_o,
    output logic [64*NUM_USER_CSR-1:0]   user_csr_o,
    output logic [NUM_USER_CSR-1:0]      user_csr_wr_o
);
    localparam logic [63:0] DFH_VAL      = 64'h1000_0100_0000_0000;
    localparam logic [14:0] QIDX_DFH     = 15'd0;
    localparam logic [14:0] QIDX_ID_L    = 15'd1;
    localparam logic [14:0] QIDX_ID_H    = 15'd2;
    localparam logic [14:0] QIDX_SCRATCH = 15'd5;
    localparam logic [14:0] QIDX_CTRL    = 15'd6;
    localparam logic [14:0] QIDX_STATUS  = 15'd7;
    localparam logic [14:0] QIDX_USER    = 15'd8;
`ifdef CCIP_MMIO_CNT_EN
    localparam logic [14:0] QIDX_CNT     = 15'(8 + NUM_USER_CSR);
`endif

    // Registers are indexed by qword: the dword address without its half-select bit.
    logic [14:0] wr_qidx;
    logic        wr_8b;
    logic        wr_hi;

    assign wr_qidx = mmio.c0_address[15:1];
    assign wr_8b   = (mmio.c0_length == 2'd1);
    assign wr_hi   = mmio.c0_address[0];

    function automatic logic [63:0] merge_wr(input logic [63:0] old_v, input logic [63:0] data,
                                             input logic is_8b, input logic hi);
        logic [63:0] r;
        if (is_8b)   r = data;
        else if (hi) r = {data[31:0], old_v[31:0]};
        else         r = {old_v[63:32], data[31:0]};
        return r;
    endfunction

    logic [63:0]                   scratch_q, scratch_d;
    logic [63:0]                   ctrl_q, ctrl_d;
    logic [NUM_USER_CSR-1:0][63:0] user_q, user_d;
    logic                          start_q, start_d;
    logic [NUM_USER_CSR-1:0]       user_wr_q, user_wr_d;

    logic        rd_valid_q, rd_valid_d;
    logic [14:0] rd_qidx_q, rd_qidx_d;
    logic        rd_8b_q, rd_8b_d;
    logic        rd_hi_q, rd_hi_d;
    logic [8:0]  rd_tid_q, rd_tid_d;

    logic        c2_valid_q, c2_valid_d;
    logic [8:0]  c2_tid_q, c2_tid_d;
    logic [63:0] c2_data_q, c2_data_d;

    logic [63:0] rd_full;
    logic [63:0] rd_sel;

`ifdef CCIP_MMIO_CNT_EN
    logic [31:0] rd_cnt_q, rd_cnt_d;
    logic [31:0] wr_cnt_q, wr_cnt_d;

    always_comb begin
        rd_cnt_d = rd_cnt_q + {31'd0, mmio.c0_mmio_rd_valid};
        wr_cnt_d = wr_cnt_q + {31'd0, mmio.c0_mmio_wr_valid};
    end
`endif

    always_comb begin
        scratch_d = scratch_q;
        ctrl_d    = ctrl_q;
        user_d    = user_q;
        start_d   = 1'b0;
        user_wr_d = '0;
        if (mmio.c0_mmio_wr_valid) begin
            if (wr_qidx == QIDX_SCRATCH) begin
                scratch_d = merge_wr(scratch_q, mmio.c0_data, wr_8b, wr_hi);
            end
            if (wr_qidx == QIDX_CTRL) begin
                ctrl_d    = merge_wr(ctrl_q, mmio.c0_data, wr_8b, wr_hi);
                // Bit 0 is a trigger, not state; only a write covering the low half can fire it.
                ctrl_d[0] = 1'b0;
                start_d   = (wr_8b || !wr_hi) && mmio.c0_data[0];
            end
            for (int i = 0; i < NUM_USER_CSR; i++) begin
                if (wr_qidx == QIDX_USER + 15'(i)) begin
                    user_d[i]    = merge_wr(user_q[i], mmio.c0_data, wr_8b, wr_hi);
                    user_wr_d[i] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        rd_valid_d = mmio.c0_mmio_rd_valid;
        rd_qidx_d  = mmio.c0_address[15:1];
        rd_8b_d    = (mmio.c0_length == 2'd1);
        rd_hi_d    = mmio.c0_address[0];
        rd_tid_d   = mmio.c0_tid;
    end

    // Stage 2 mux reads the already-updated register flops, so a write in the request cycle is seen.
    always_comb begin
        rd_full = '0;
        case (rd_qidx_q)
            QIDX_DFH:     rd_full = DFH_VAL;
            QIDX_ID_L:    rd_full = AFU_ID_L;
            QIDX_ID_H:    rd_full = AFU_ID_H;
            QIDX_SCRATCH: rd_full = scratch_q;
            QIDX_CTRL:    rd_full = ctrl_q;
            QIDX_STATUS:  rd_full = status_i;
            default:      rd_full = '0;
        endcase
        for (int i = 0; i < NUM_USER_CSR; i++) begin
            if (rd_qidx_q == QIDX_USER + 15'(i)) rd_full = user_q[i];
        end
`ifdef CCIP_MMIO_CNT_EN
        if (rd_qidx_q == QIDX_CNT) rd_full = {rd_cnt_q, wr_cnt_q};
`endif
    end

    always_comb begin
        if (rd_8b_q)      rd_sel = rd_full;
        else if (rd_hi_q) rd_sel = {32'h0, rd_full[63:32]};
        else              rd_sel = {32'h0, rd_full[31:0]};
        c2_valid_d = rd_valid_q;
        c2_tid_d   = rd_valid_q ? rd_tid_q : 9'h0;
        c2_data_d  = rd_valid_q ? rd_sel : 64'h0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scratch_q  <= '0;
            ctrl_q     <= '0;
            user_q     <= '0;
            start_q    <= 1'b0;
            user_wr_q  <= '0;
            rd_valid_q <= 1'b0;
            rd_qidx_q  <= '0;
            rd_8b_q    <= 1'b0;
            rd_hi_q    <= 1'b0;
            rd_tid_q   <= '0;
            c2_valid_q <= 1'b0;
            c2_tid_q   <= '0;
            c2_data_q  <= '0;
        end else begin
            scratch_q  <= scratch_d;
            ctrl_q     <= ctrl_d;
            user_q     <= user_d;
            start_q    <= start_d;
            user_wr_q  <= user_wr_d;
            rd_valid_q <= rd_valid_d;
            rd_qidx_q  <= rd_qidx_d;
            rd_8b_q    <= rd_8b_d;
            rd_hi_q    <= rd_hi_d;
            rd_tid_q   <= rd_tid_d;
            c2_valid_q <= c2_valid_d;
            c2_tid_q   <= c2_tid_d;
            c2_data_q  <= c2_data_d;
        end
    end

`ifdef CCIP_MMIO_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
        end else begin
            rd_cnt_q <= rd_cnt_d;
            wr_cnt_q <= wr_cnt_d;
        end
    end
`endif

    assign ctrl_o                = ctrl_q;
    assign start_o               = start_q;
    assign user_csr_o            = user_q;
    assign user_csr_wr_o         = user_wr_q;
    assign mmio.c2_mmio_rd_valid = c2_valid_q;
    assign mmio.c2_tid           = c2_tid_q;
    assign mmio.c2_data          = c2_data_q;
endmodule

// File: tb/tb_ccip_mmio_csr_responder.sv
// tb/tb_ccip_mmio_csr_responder.sv - randomized and directed checks of the MMIO CSR responder
// A byte-address register model predicts every response, pulse and CSR output.
module tb_ccip_mmio_csr_responder;
    localparam int          NUM  = 8;
    localparam logic [63:0] ID_L = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] ID_H = 64'hFEDC_BA98_7654_3210;
    localparam logic [63:0] DFH  = 64'h1000_0100_0000_0000;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic [63:0]          status_i = 64'h5A5A_0000_1234_8765;
    logic [63:0]          ctrl_o;
    logic                 start_o;
    logic [64*NUM-1:0]    user_csr_o;
    logic [NUM-1:0]       user_csr_wr_o;

    ccip_mmio_csr_responder_if mmio ();

    ccip_mmio_csr_responder #(
        .AFU_ID_L     (ID_L),
        .AFU_ID_H     (ID_H),
        .NUM_USER_CSR (NUM)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .mmio          (mmio),
        .status_i      (status_i),
        .ctrl_o        (ctrl_o),
        .start_o       (start_o),
        .user_csr_o    (user_csr_o),
        .user_csr_wr_o (user_csr_wr_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    typedef struct packed {
        logic        v;
        logic [8:0]  tid;
        logic [63:0] data;
    } resp_t;

    logic [63:0]    m_scratch, m_ctrl;
    logic [63:0]    m_user [NUM];
    logic [31:0]    m_rd_cnt, m_wr_cnt;
    resp_t          r1, r2;
    logic           exp_start;
    logic [NUM-1:0] exp_uwr;

    logic           seen_v, seen_start;
    logic [8:0]     seen_tid;
    logic [63:0]    seen_data, seen_ctrl;
    logic [NUM-1:0] seen_uwr;

    function automatic logic [63:0] m_reg(input int unsigned qb);
        if (qb == 32'h00) return DFH;
        if (qb == 32'h08) return ID_L;
        if (qb == 32'h10) return ID_H;
        if (qb == 32'h28) return m_scratch;
        if (qb == 32'h30) return m_ctrl;
        if (qb == 32'h38) return status_i;
        if (qb >= 32'h40 && qb < 32'h40 + 8 * NUM) return m_user[(qb - 32'h40) / 8];
`ifdef CCIP_MMIO_CNT_EN
        if (qb == 32'h40 + 8 * NUM) return {m_rd_cnt, m_wr_cnt};
`endif
        return 64'h0;
    endfunction

    function automatic int unsigned qbyte(input logic [15:0] addr);
        return (32'(addr) & 32'hFFFF_FFFE) << 2;
    endfunction

    function automatic logic [63:0] m_read(input logic [15:0] addr, input logic [1:0] len);
        logic [63:0] full;
        full = m_reg(qbyte(addr));
        if (len == 2'd1) return full;
        return addr[0] ? {32'h0, full[63:32]} : {32'h0, full[31:0]};
    endfunction

    task automatic m_write(input logic [15:0] addr, input logic [1:0] len, input logic [63:0] data);
        int unsigned qb;
        logic [63:0] old_v, new_v;
        qb    = qbyte(addr);
        old_v = m_reg(qb);
        if (len == 2'd1)  new_v = data;
        else if (addr[0]) new_v = {data[31:0], old_v[31:0]};
        else              new_v = {old_v[63:32], data[31:0]};
        if (qb == 32'h28) m_scratch = new_v;
        if (qb == 32'h30) begin
            m_ctrl    = new_v & ~64'h1;
            exp_start = data[0] && (len == 2'd1 || !addr[0]);
        end
        if (qb >= 32'h40 && qb < 32'h40 + 8 * NUM) begin
            m_user[(qb - 32'h40) / 8]  = new_v;
            exp_uwr[(qb - 32'h40) / 8] = 1'b1;
        end
        m_wr_cnt++;
    endtask

    task automatic m_clear();
        m_scratch = '0;
        m_ctrl    = '0;
        for (int i = 0; i < NUM; i++) m_user[i] = '0;
        m_rd_cnt  = '0;
        m_wr_cnt  = '0;
        r1        = '0;
        r2        = '0;
        exp_start = 1'b0;
        exp_uwr   = '0;
    endtask

    task automatic drive_idle();
        mmio.c0_mmio_rd_valid = 1'b0;
        mmio.c0_mmio_wr_valid = 1'b0;
        mmio.c0_address       = '0;
        mmio.c0_length        = '0;
        mmio.c0_tid           = '0;
        mmio.c0_data          = '0;
    endtask

    // One clock cycle: check what the DUT shows in this cycle, then present this cycle's request.
    task automatic step(input logic rd, input logic wr, input logic [15:0] addr,
                        input logic [1:0] len, input logic [8:0] tid, input logic [63:0] data);
        logic [64*NUM-1:0] exp_flat;
        resp_t             r0;
        @(posedge clk);
        #1;
        for (int i = 0; i < NUM; i++) exp_flat[64*i +: 64] = m_user[i];
        check("c2_valid", 512'(mmio.c2_mmio_rd_valid), 512'(r2.v));
        if (r2.v) begin
            check("c2_tid", 512'(mmio.c2_tid), 512'(r2.tid));
            check("c2_data", 512'(mmio.c2_data), 512'(r2.data));
        end
        check("start_o", 512'(start_o), 512'(exp_start));
        check("user_csr_wr_o", 512'(user_csr_wr_o), 512'(exp_uwr));
        check("ctrl_o", 512'(ctrl_o), 512'(m_ctrl));
        check("user_csr_o", 512'(user_csr_o), 512'(exp_flat));
        seen_v     = mmio.c2_mmio_rd_valid;
        seen_tid   = mmio.c2_tid;
        seen_data  = mmio.c2_data;
        seen_start = start_o;
        seen_uwr   = user_csr_wr_o;
        seen_ctrl  = ctrl_o;

        mmio.c0_mmio_rd_valid = rd;
        mmio.c0_mmio_wr_valid = wr;
        mmio.c0_address       = addr;
        mmio.c0_length        = len;
        mmio.c0_tid           = tid;
        mmio.c0_data          = data;

        exp_start = 1'b0;
        exp_uwr   = '0;
        if (wr) m_write(addr, len, data);
        r0 = '0;
        if (rd) begin
            m_rd_cnt++;
            r0.v    = 1'b1;
            r0.tid  = tid;
            r0.data = m_read(addr, len);
        end
        r2 = r1;
        r1 = r0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'h0, 2'd0, 9'h0, 64'h0);
    endtask

    // Asserts reset between clock edges, so anything requested in the current cycle is lost.
    task automatic apply_reset();
        #2;
        reset = 1'b1;
        drive_idle();
        m_clear();
        @(posedge clk);
        @(posedge clk);
        #1;
        check("rst_ctrl_o", 512'(ctrl_o), 512'(0));
        check("rst_start_o", 512'(start_o), 512'(0));
        check("rst_user_csr_o", 512'(user_csr_o), 512'(0));
        check("rst_user_wr_o", 512'(user_csr_wr_o), 512'(0));
        check("rst_c2_valid", 512'(mmio.c2_mmio_rd_valid), 512'(0));
        check("rst_c2_tid", 512'(mmio.c2_tid), 512'(0));
        check("rst_c2_data", 512'(mmio.c2_data), 512'(0));
        reset = 1'b0;
    endtask

    initial begin
        drive_idle();
        m_clear();
        apply_reset();

        // T1: DFH read, response two cycles later
        step(1'b1, 1'b0, 16'h0000, 2'd1, 9'h05, 64'h0);
        idle(2);
        check("t1_valid", 512'(seen_v), 512'(1));
        check("t1_tid", 512'(seen_tid), 512'(9'h05));
        check("t1_dfh", 512'(seen_data), 512'(DFH));

        // T2: full then half write of SCRATCH
        step(1'b0, 1'b1, 16'h000A, 2'd1, 9'h0, 64'hDEAD_BEEF_0123_4567);
        step(1'b0, 1'b1, 16'h000B, 2'd0, 9'h0, 64'h0000_0000_CAFE_F00D);
        step(1'b1, 1'b0, 16'h000A, 2'd1, 9'h11, 64'h0);
        step(1'b1, 1'b0, 16'h000B, 2'd0, 9'h12, 64'h0);
        idle(1);
        check("t2_scratch_8b", 512'(seen_data), 512'(64'hCAFE_F00D_0123_4567));
        idle(1);
        check("t2_scratch_4b", 512'(seen_data), 512'(64'h0000_0000_CAFE_F00D));

        // T3: CTRL write with bit 0 set
        step(1'b0, 1'b1, 16'h000C, 2'd1, 9'h0, 64'h3);
        idle(1);
        check("t3_start", 512'(seen_start), 512'(1));
        check("t3_ctrl_o", 512'(seen_ctrl), 512'(64'h2));
        step(1'b1, 1'b0, 16'h000C, 2'd1, 9'h07, 64'h0);
        idle(1);
        check("t3_start_once", 512'(seen_start), 512'(0));
        idle(1);
        check("t3_ctrl_rd", 512'(seen_data), 512'(64'h2));

        // T4: back-to-back reads, write to USER_CSR[0] alongside read 1
        step(1'b1, 1'b1, 16'h0010, 2'd1, 9'h01, 64'hA5A5_1111_2222_3333);
        step(1'b1, 1'b0, 16'h0012, 2'd1, 9'h02, 64'h0);
        check("t4_uwr", 512'(seen_uwr), 512'(1));
        step(1'b1, 1'b0, 16'h000A, 2'd1, 9'h03, 64'h0);
        check("t4_rd1_tid", 512'(seen_tid), 512'(9'h01));
        check("t4_rd1_new", 512'(seen_data), 512'(64'hA5A5_1111_2222_3333));
        check("t4_uwr_once", 512'(seen_uwr), 512'(0));
        step(1'b1, 1'b0, 16'h000C, 2'd1, 9'h04, 64'h0);
        check("t4_rd2_tid", 512'(seen_tid), 512'(9'h02));
        idle(2);
        check("t4_rd4_tid", 512'(seen_tid), 512'(9'h04));

        // T5: unmapped read, RO write, reset with a read in flight
        step(1'b1, 1'b0, 16'h3FF0, 2'd1, 9'h09, 64'h0);
        idle(2);
        check("t5_unmapped", 512'(seen_data), 512'(0));
        step(1'b0, 1'b1, 16'h0000, 2'd1, 9'h0, 64'hFFFF_FFFF_FFFF_FFFF);
        step(1'b1, 1'b0, 16'h0000, 2'd1, 9'h0A, 64'h0);
        idle(2);
        check("t5_dfh_ro", 512'(seen_data), 512'(DFH));
        step(1'b1, 1'b0, 16'h000A, 2'd1, 9'h33, 64'h0);
        idle(1);
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            idle(1);
            check("t5_no_resp", 512'(seen_v), 512'(0));
        end

`ifdef CCIP_MMIO_CNT_EN
        // T6: counters see three writes and, including this one, three reads
        step(1'b0, 1'b1, 16'h000A, 2'd1, 9'h0, 64'h1);
        step(1'b1, 1'b0, 16'h0000, 2'd1, 9'h01, 64'h0);
        step(1'b0, 1'b1, 16'h0012, 2'd0, 9'h0, 64'h2);
        step(1'b1, 1'b0, 16'h000A, 2'd1, 9'h02, 64'h0);
        step(1'b0, 1'b1, 16'h000D, 2'd0, 9'h0, 64'h3);
        step(1'b1, 1'b0, 16'((8'h40 + 8 * NUM) / 4), 2'd1, 9'h03, 64'h0);
        idle(2);
        check("t6_counters", 512'(seen_data), 512'(64'h0000_0003_0000_0003));
`endif

        // Random mix of reads and writes across the map and beyond it
        for (int n = 0; n < 600; n++) begin
            logic        rd, wr;
            logic [15:0] addr;
            logic [1:0]  len;
            rd   = ($urandom_range(0, 99) < 55);
            wr   = ($urandom_range(0, 99) < 45);
            len  = 2'($urandom_range(0, 1));
            addr = ($urandom_range(0, 15) == 0) ? 16'($urandom)
                                                : 16'($urandom_range(0, 2 * (8 + NUM + 2) - 1));
            if (len == 2'd1) addr[0] = 1'b0;
            step(rd, wr, addr, len, 9'($urandom), {$urandom, $urandom});
            if (n == 300) begin
                idle(1);
                apply_reset();
            end
        end
        idle(3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule
